// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the serial digit adder.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  function automatic bit digit_ok(input int unsigned w, input int unsigned d);
    return (d >= 1) && (d <= w) && ((w % d) == 0);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder built from full_adder cells.
// c_msb (carry into the top bit) exists only with SERIAL_DIGIT_ADDER_OVF_EN.
module digit_adder #(
  parameter int unsigned DIGIT = 8
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
`ifdef SERIAL_DIGIT_ADDER_OVF_EN
  output logic             c_msb,
`endif
  output logic             co
);

  logic [DIGIT:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder u_fa (
      .a  (x[i]),
      .b  (y[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co = c[DIGIT];
`ifdef SERIAL_DIGIT_ADDER_OVF_EN
  assign c_msb = c[DIGIT-1];
`endif

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_digit_adder.sv
// Multi-cycle WIDTH-bit adder, DIGIT bits per clock with registered carry.
// Optional signed-overflow output enabled by SERIAL_DIGIT_ADDER_OVF_EN.
module serial_digit_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_DIGIT_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             c_out
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (clog2(N) > 1) ? clog2(N) : 1;

  if (!digit_ok(WIDTH, DIGIT)) begin : g_bad_param
    $error("serial_digit_adder: WIDTH must be a non-zero multiple of DIGIT");
  end

  state_t             state;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH-1:0]   sum_r;
  logic               cy;
  logic [CNT_W-1:0]   cnt;
  logic [DIGIT-1:0]   d_s;
  logic               d_co;
`ifdef SERIAL_DIGIT_ADDER_OVF_EN
  logic               d_cmsb;
  logic               ovf_r;
`endif

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x     (opa[DIGIT-1:0]),
    .y     (opb[DIGIT-1:0]),
    .ci    (cy),
    .s     (d_s),
`ifdef SERIAL_DIGIT_ADDER_OVF_EN
    .c_msb (d_cmsb),
`endif
    .co    (d_co)
  );

  assign in_ready = (state == ST_IDLE);
  assign sum      = sum_r;
  assign c_out    = cy;
`ifdef SERIAL_DIGIT_ADDER_OVF_EN
  assign ovf      = ovf_r;
`endif

  // The digit result enters at the top so after N steps digit 0 sits at bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      opa       <= '0;
      opb       <= '0;
      sum_r     <= '0;
      cy        <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
`ifdef SERIAL_DIGIT_ADDER_OVF_EN
      ovf_r     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            opa   <= a;
            opb   <= b;
            cy    <= c_in;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_r <= WIDTH'({d_s, sum_r} >> DIGIT);
          opa   <= opa >> DIGIT;
          opb   <= opb >> DIGIT;
          cy    <= d_co;
          cnt   <= cnt + 1'b1;
`ifdef SERIAL_DIGIT_ADDER_OVF_EN
          ovf_r <= d_cmsb ^ d_co;
`endif
          if (cnt == CNT_W'(N - 1)) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_digit_adder.sv
// Directed and random checks of serial_digit_adder at several WIDTH/DIGIT settings.
module tb_serial_digit_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv0, rdy0, iv_o, rdy_o;
  logic [31:0] a, b;
  logic        c_in;

  logic        ir0, ov0, co0;
  logic [31:0] s0;
  logic        ir1, ov1, co1;
  logic [31:0] s1;
  logic        ir2, ov2, co2;
  logic [31:0] s2;
  logic        ir3, ov3, co3;
  logic [15:0] s3;
`ifdef SERIAL_DIGIT_ADDER_OVF_EN
  logic        ovf0, ovf1, ovf2, ovf3;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [15:0] last_s16;
  logic        last_co16;

  always #5 clk = ~clk;

  serial_digit_adder #(.WIDTH(32), .DIGIT(8)) dut_w32d8 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a), .b(b), .c_in(c_in),
    .out_valid(ov0), .out_ready(rdy0), .sum(s0),
`ifdef SERIAL_DIGIT_ADDER_OVF_EN
    .ovf(ovf0),
`endif
    .c_out(co0));

  serial_digit_adder #(.WIDTH(32), .DIGIT(1)) dut_w32d1 (
    .clk(clk), .rst(rst), .in_valid(iv_o), .in_ready(ir1), .a(a), .b(b), .c_in(c_in),
    .out_valid(ov1), .out_ready(rdy_o), .sum(s1),
`ifdef SERIAL_DIGIT_ADDER_OVF_EN
    .ovf(ovf1),
`endif
    .c_out(co1));

  serial_digit_adder #(.WIDTH(32), .DIGIT(32)) dut_w32d32 (
    .clk(clk), .rst(rst), .in_valid(iv_o), .in_ready(ir2), .a(a), .b(b), .c_in(c_in),
    .out_valid(ov2), .out_ready(rdy_o), .sum(s2),
`ifdef SERIAL_DIGIT_ADDER_OVF_EN
    .ovf(ovf2),
`endif
    .c_out(co2));

  serial_digit_adder #(.WIDTH(16), .DIGIT(4)) dut_w16d4 (
    .clk(clk), .rst(rst), .in_valid(iv_o), .in_ready(ir3), .a(a[15:0]), .b(b[15:0]), .c_in(c_in),
    .out_valid(ov3), .out_ready(rdy_o), .sum(s3),
`ifdef SERIAL_DIGIT_ADDER_OVF_EN
    .ovf(ovf3),
`endif
    .c_out(co3));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One operation on all four adders; es/eco/eovf are the 32-bit expectations.
  task automatic op(input logic [31:0] ta, input logic [31:0] tb_, input logic tc,
                    input logic [31:0] es, input logic eco, input logic eovf);
    logic [16:0] m16;
    int          l [4];
    logic [31:0] rs [3];
    logic        rc [4];
    logic [15:0] r16;
    logic        rovf;
    m16 = {1'b0, ta[15:0]} + {1'b0, tb_[15:0]} + 17'(tc);
    l = '{-1, -1, -1, -1};
    rovf = 1'bx;
    @(negedge clk);
    a = ta; b = tb_; c_in = tc; iv0 = 1'b1; iv_o = 1'b1; rdy0 = 1'b1; rdy_o = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv0 = 1'b0; iv_o = 1'b0;
    check("busy_after_accept", 64'(ir0), 64'd0);
    for (int cyc = 0; cyc <= 40; cyc++) begin
      if (ov0 && l[0] < 0) begin
        l[0] = cyc; rs[0] = s0; rc[0] = co0;
        check("busy_in_done", 64'(ir0), 64'd0);
`ifdef SERIAL_DIGIT_ADDER_OVF_EN
        rovf = ovf0;
`endif
      end
      if (ov1 && l[1] < 0) begin l[1] = cyc; rs[1] = s1; rc[1] = co1; end
      if (ov2 && l[2] < 0) begin l[2] = cyc; rs[2] = s2; rc[2] = co2; end
      if (ov3 && l[3] < 0) begin l[3] = cyc; r16 = s3; rc[3] = co3; end
      if (l[0] >= 0 && l[1] >= 0 && l[2] >= 0 && l[3] >= 0) break;
      @(negedge clk);
    end
    check("sum_w32d8", 64'(rs[0]), 64'(es));
    check("cout_w32d8", 64'(rc[0]), 64'(eco));
    check("sum_w32d1", 64'(rs[1]), 64'(es));
    check("cout_w32d1", 64'(rc[1]), 64'(eco));
    check("sum_w32d32", 64'(rs[2]), 64'(es));
    check("cout_w32d32", 64'(rc[2]), 64'(eco));
    check("sum_w16d4", 64'(r16), 64'(m16[15:0]));
    check("cout_w16d4", 64'(rc[3]), 64'(m16[16]));
    check("lat_w32d8", 64'(l[0]), 64'd4);
    check("lat_w32d1", 64'(l[1]), 64'd32);
    check("lat_w32d32", 64'(l[2]), 64'd1);
    check("lat_w16d4", 64'(l[3]), 64'd4);
`ifdef SERIAL_DIGIT_ADDER_OVF_EN
    check("ovf_w32d8", 64'(rovf), 64'(eovf));
`else
    if (eovf === 1'bx) rovf = 1'b0;
`endif
    last_s16 = r16;
    last_co16 = rc[3];
    @(negedge clk);
  endtask

  task automatic rand_op();
    logic [31:0] x, y;
    logic        z;
    logic [32:0] m;
    x = $urandom; y = $urandom; z = 1'($urandom_range(0, 1));
    m = {1'b0, x} + {1'b0, y} + 33'(z);
    op(x, y, z, m[31:0], m[32], (x[31] == y[31]) && (m[31] != x[31]));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ba [4];
    logic [31:0] bb [4];
    logic [31:0] bs [4];
    logic        bc [4];
    int          kin, kout, last;

    ba = '{32'h0000_0001, 32'h0000_0100, 32'hFFFF_FFFF, 32'h8000_0000};
    bb = '{32'h0000_0002, 32'h0000_0200, 32'h0000_0001, 32'h8000_0000};
    bs = '{32'h0000_0003, 32'h0000_0300, 32'h0000_0000, 32'h0000_0000};
    bc = '{1'b0, 1'b0, 1'b1, 1'b1};

    rst = 1'b1; iv0 = 1'b0; iv_o = 1'b0; rdy0 = 1'b1; rdy_o = 1'b1;
    a = '0; b = '0; c_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(ov0), 64'd0);
    check("rst_sum", 64'(s0), 64'd0);
    check("rst_cout", 64'(co0), 64'd0);
    check("rst_valid_w16", 64'(ov3), 64'd0);
`ifdef SERIAL_DIGIT_ADDER_OVF_EN
    check("rst_ovf", 64'(ovf0), 64'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(ir0), 64'd1);

    op(32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
    op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1);
    op(32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
    check("w16_wrap_sum", 64'(last_s16), 64'h0);
    check("w16_wrap_cout", 64'(last_co16), 64'd1);

    // Backpressure: result must hold and a new request must be ignored.
    @(negedge clk);
    a = 32'h0000_00FF; b = 32'h0000_0001; c_in = 1'b0; iv0 = 1'b1; rdy0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    iv0 = 1'b0; a = 32'hDEAD_BEEF;
    for (int i = 0; i < 20 && !ov0; i++) @(negedge clk);
    check("bp_valid_rise", 64'(ov0), 64'd1);
    for (int i = 0; i < 10; i++) begin
      check("bp_sum", 64'(s0), 64'h100);
      check("bp_cout", 64'(co0), 64'd0);
      check("bp_valid", 64'(ov0), 64'd1);
      check("bp_ready", 64'(ir0), 64'd0);
      if (i == 3) begin iv0 = 1'b1; a = 32'h1; b = 32'h1; end
      else iv0 = 1'b0;
      @(negedge clk);
    end
    iv0 = 1'b0; rdy0 = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 64'(ov0), 64'd0);
    check("bp_release_ready", 64'(ir0), 64'd1);

    // Reset during RUN after one digit step has left state in the registers.
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; c_in = 1'b0; iv0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_valid", 64'(ov0), 64'd0);
    check("midrst_sum", 64'(s0), 64'd0);
    check("midrst_cout", 64'(co0), 64'd0);
    repeat (3) @(negedge clk);
    check("midrst_hold_valid", 64'(ov0), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrst_no_valid", 64'(ov0), 64'd0);
    end
    check("midrst_ready", 64'(ir0), 64'd1);
    op(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

    // Back-to-back with in_valid held high: one result every N+2 cycles.
    @(negedge clk);
    rdy0 = 1'b1; iv0 = 1'b1; c_in = 1'b0;
    kin = 0; kout = 0; last = 0;
    for (int cyc = 0; cyc <= 80; cyc++) begin
      if (ir0) begin
        if (kin < 4) begin a = ba[kin]; b = bb[kin]; kin++; end
        else iv0 = 1'b0;
      end
      if (ov0) begin
        check("b2b_sum", 64'(s0), 64'(bs[kout]));
        check("b2b_cout", 64'(co0), 64'(bc[kout]));
        if (kout > 0) check("b2b_gap", 64'(cyc - last), 64'd6);
        last = cyc;
        kout++;
      end
      if (kout == 4) break;
      @(negedge clk);
    end
    iv0 = 1'b0;
    check("b2b_count", 64'(kout), 64'd4);
    repeat (2) @(negedge clk);

    for (int i = 0; i < 1000; i++) rand_op();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
